uart_rx_byte: RTL and testbench

UART receiver that turns the serial debug line into 8-bit bytes for the pipeline debug/step logic. It oversamples the asynchronous `rx` pin, reassembles 8N1 frames LSB-first, and presents each byte as a held value plus a one-cycle strobed copy. The strobed copy is the direct feed for the step-command detector, so back-to-back identical command bytes each produce their own event.

---
 rtl/uart_rx_byte.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with 16x oversampling.
//
// The asynchronous rx pin is synchronized, and the receiver locates the middle
// of the start bit. Eight data bits are then sampled LSB-first, one bit period
// apart, followed by the stop bit. A good frame updates the held byte and for
// one cycle presents a strobed copy alongside rxDone. A bad stop bit pulses
// frameErr, and the receiver waits for the line to go idle (high) again.
//
// Parameters
//   CLK_FREQ    clock frequency in Hz
//   BAUD        line bit rate
//   OVERSAMPLE  ticks per bit (only 16 is supported)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   rx           asynchronous serial input, idles high
//   outDato      last good byte, held until the next good frame
//   outDatoStrb  received byte during the rxDone cycle, 0x00 otherwise
//   rxDone       one-cycle pulse per good frame
//   frameErr     one-cycle pulse per frame with a low stop bit
module uart_rx_byte #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] outDato,
  output logic [7:0] outDatoStrb,
  output logic       rxDone,
  output logic       frameErr
);

  // Clocks per oversample tick. Integer floor; must be at least 2.
  localparam int D  = CLK_FREQ / (BAUD * 16);
  localparam int DW = (D > 2) ? $clog2(D) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(D - 1);
  localparam logic [3:0]    TICK_LAST = 4'(OVERSAMPLE - 1);     // 16th tick of a bit
  localparam logic [3:0]    TICK_MID  = 4'(OVERSAMPLE / 2 - 1); // 8th tick: mid start bit

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Synchronizer
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          rxs;

  // Receiver state
  state_t        state_q, state_d;
  logic [DW-1:0] div_q,   div_d;
  logic [3:0]    tick_q,  tick_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shreg_q, shreg_d;

  // Registered outputs
  logic [7:0]    dato_q,  dato_d;
  logic [7:0]    strb_q,  strb_d;
  logic          done_q,  done_d;
  logic          ferr_q,  ferr_d;

  logic          tick;

  assign rxs = sync2_q;

  // The divider wraps once every D clocks. That wrap is the oversample tick.
  assign tick = (div_q == DIV_LAST);

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;

    state_d = state_q;
    div_d   = div_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dato_d  = dato_q;
    // The strobe and pulses are single-cycle and default to idle.
    strb_d  = 8'h00;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    // The divider is held at zero in IDLE. While a frame is in progress it
    // free-runs, so bit timing stays referenced to the detected start edge.
    if (state_q == ST_IDLE) begin
      div_d = '0;
    end else if (tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          div_d   = '0;
          tick_d  = 4'd0;
          bit_d   = 3'd0;
        end
      end

      ST_START: begin
        if (tick) begin
          if (tick_q == TICK_MID) begin
            // If the line is still low at mid start bit, treat this as a real
            // start bit. If it has gone high, it was a glitch: drop it silently.
            tick_d = 4'd0;
            if (!rxs) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = 4'd0;
            // Data arrives LSB-first, so shift in from the top.
            shreg_d = {rxs, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = ST_STOP;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d = 4'd0;
            if (rxs) begin
              dato_d  = shreg_q;
              strb_d  = shreg_q;
              done_d  = 1'b1;
              // Returning at mid stop bit leaves half a bit of margin for a
              // back-to-back start edge.
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      ST_BREAK: begin
        // A low stop bit may be a break condition. Do not look for a new start
        // bit until the line has returned high.
        tick_d = 4'd0;
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_IDLE;
      div_q   <= '0;
      tick_q  <= 4'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      dato_q  <= 8'h00;
      strb_q  <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      dato_q  <= dato_d;
      strb_q  <= strb_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign outDato     = dato_q;
  assign outDatoStrb = strb_q;
  assign rxDone      = done_q;
  assign frameErr    = ferr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte. Stimulus pushes one expected event per
// frame. A negedge monitor pops an entry for each rxDone/frameErr pulse and
// checks the kind of event, the data, the held byte, the latency and, where
// requested, the spacing from the previous event.
module tb_uart_rx_byte;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT      = 160;        // clocks per bit, D = 10
  localparam int LAT_MIN  = 1523;       // 152*D + 4, +/-1
  localparam int LAT_MAX  = 1525;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] outDato;
  logic [7:0] outDatoStrb;
  logic       rxDone;
  logic       frameErr;

  typedef struct {
    logic       err;
    logic [7:0] data;
    logic [7:0] held;
    int         start;
    int         gap;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   last_evt = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] model_held = 8'h00;

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .outDato(outDato),
    .outDatoStrb(outDatoStrb), .rxDone(rxDone), .frameErr(frameErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame that starts at the current negedge and returns at the end
  // of the stop bit. A stop bit of 0 means a framing error is expected.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int gap);
    exp_t e;
    e.err   = ~stop_b;
    e.data  = b;
    e.start = cyc;
    e.gap   = gap;
    if (stop_b) model_held = b;
    e.held  = model_held;
    sbq.push_back(e);
    rx = 1'b0;
    wait_cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(BIT);
    end
    rx = stop_b;
    wait_cycles(BIT);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending"}, sbq.size(), 0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (rxDone && frameErr) begin
        miscompares++;
        $display("FAIL pulse_overlap: rxDone and frameErr both high at cycle %0d", cyc);
      end
      if (!rxDone && outDatoStrb != 8'h00) begin
        miscompares++;
        $display("FAIL strobe_idle: outDatoStrb=%0h without rxDone at cycle %0d", outDatoStrb, cyc);
      end
      if (rxDone || frameErr) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: rxDone=%0b frameErr=%0b strb=%0h at cycle %0d",
                   rxDone, frameErr, outDatoStrb, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("event_is_err", frameErr, e.err);
          if (rxDone) chk("strobe_data", outDatoStrb, e.data);
          chk("held_data", outDato, e.held);
          chk_rng("latency", cyc - e.start, LAT_MIN, LAT_MAX);
          if (e.gap != 0) chk_rng("event_gap", cyc - last_evt, e.gap - 20, e.gap + 20);
        end
        last_evt = cyc;
      end
    end
  end

  initial begin
    #(1_000_000);
    $display("FAIL timeout: bench did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(2);
    chk("reset_dato", outDato, 8'h00);
    chk("reset_strb", outDatoStrb, 8'h00);
    chk("reset_done", rxDone, 1'b0);
    chk("reset_ferr", frameErr, 1'b0);
    wait_cycles(20);

    // Single byte
    send_frame(8'h73, 1'b1, 0);
    wait_cycles(20);
    drain("single");
    chk("single_held", outDato, 8'h73);
    chk("single_strb_clr", outDatoStrb, 8'h00);
    wait_cycles(100);

    // Back-to-back identical bytes: each one produces its own event
    send_frame(8'h73, 1'b1, 0);
    send_frame(8'h73, 1'b1, 1600);
    wait_cycles(20);
    drain("b2b");
    wait_cycles(100);

    // Bit order, then a zero byte
    send_frame(8'hA5, 1'b1, 0);
    wait_cycles(20);
    chk("a5_held", outDato, 8'hA5);
    send_frame(8'h00, 1'b1, 0);
    wait_cycles(20);
    drain("order");
    chk("zero_held", outDato, 8'h00);
    wait_cycles(100);

    // Glitch shorter than half a bit
    rx = 1'b0;
    wait_cycles(50);
    rx = 1'b1;
    wait_cycles(300);
    chk("glitch_held", outDato, 8'h00);
    send_frame(8'h31, 1'b1, 0);
    wait_cycles(20);
    drain("glitch");
    chk("after_glitch", outDato, 8'h31);
    wait_cycles(100);

    // Framing error with the line held low afterwards
    send_frame(8'h55, 1'b0, 0);
    wait_cycles(340);
    rx = 1'b1;
    wait_cycles(100);
    drain("ferr");
    chk("ferr_held", outDato, 8'h31);
    send_frame(8'h73, 1'b1, 0);
    wait_cycles(20);
    drain("post_ferr");
    chk("post_ferr_held", outDato, 8'h73);
    wait_cycles(100);

    // Reset during data bit 4 of a 0xFF frame: no event is expected
    rx = 1'b0;
    wait_cycles(BIT);
    rx = 1'b1;
    wait_cycles(4 * BIT + 80);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    model_held = 8'h00;
    chk("rst_mid_dato", outDato, 8'h00);
    chk("rst_mid_strb", outDatoStrb, 8'h00);
    chk("rst_mid_done", rxDone, 1'b0);
    chk("rst_mid_ferr", frameErr, 1'b0);
    wait_cycles(1000);
    chk("rst_mid_quiet", outDato, 8'h00);
    send_frame(8'h12, 1'b1, 0);
    wait_cycles(20);
    drain("post_rst");
    chk("post_rst_held", outDato, 8'h12);

    wait_cycles(50);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
